// File: rtl/instruction_memory_ctrl_pkg.sv
// Shared types and helpers for the instruction memory controller.
package imem_pkg;

   typedef enum logic [1:0] {
      ST_CLEAR = 2'd0,
      ST_IDLE  = 2'd1,
      ST_LOAD  = 2'd2
   } imem_state_e;

   localparam logic [31:0] DEFAULT_FILL_WORD = 32'hDEADBEEF;

   // Index arithmetic is done at this width so range checks never truncate.
   localparam int IDX_W = 64;

   function automatic logic [IDX_W-1:0] word_index(input logic [IDX_W-1:0] addr,
                                                   input logic             byte_addr);
      return byte_addr ? (addr >> 2) : addr;
   endfunction

endpackage

// File: rtl/instruction_memory_ctrl_ram.sv
// DEPTH x DATA_W array with one write port and one registered read port.
module imem_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     raddr_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rdata_q;

   // Read data only moves on an enabled read, so a stalled response holds.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_memory_ctrl.sv
// Instruction memory: fill sweep after reset, registered valid/ready fetch port, burst loader.
module instruction_memory_ctrl
   import imem_pkg::*;
#(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 1024,
   parameter logic [DATA_W-1:0] FILL_WORD = DEFAULT_FILL_WORD,
   parameter int                BYTE_ADDR = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_valid,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instruction,
   output logic              instr_fault,
   input  logic              instr_ready,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic [ADDR_W-1:0] load_len,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        dbg_state
);

   localparam int             AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [IDX_W-1:0] DEPTH_X = IDX_W'(DEPTH);

   imem_state_e       state_q, state_d;
   logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic              load_done_q, load_done_d;
   logic              load_err_q, load_err_d;
   logic              iv_q, fault_q, use_fill_q;

   logic [IDX_W-1:0]  fetch_idx;
   logic [IDX_W-1:0]  ptr_x;
   logic              misaligned, fetch_bad, fetch_acc, beat, ptr_ok;
   logic              ram_we, ram_re;
   logic [AW-1:0]     ram_waddr;
   logic [DATA_W-1:0] ram_wdata, ram_rdata;

   assign fetch_idx  = word_index(IDX_W'(fetch_addr), BYTE_ADDR != 0);
   assign misaligned = (BYTE_ADDR != 0) && (fetch_addr[1:0] != 2'b00);
   assign fetch_bad  = misaligned || (fetch_idx >= DEPTH_X);

   // load_start wins over a same-cycle fetch, so the fetch must not see ready.
   assign fetch_ready = (state_q == ST_IDLE) && !load_start && (!iv_q || instr_ready);
   assign fetch_acc   = fetch_valid && fetch_ready;

   assign load_ready = (state_q == ST_LOAD);
   assign beat       = load_valid && load_ready;
   assign ptr_x      = IDX_W'(ptr_q);
   assign ptr_ok     = ptr_x < DEPTH_X;

   assign ram_we    = (state_q == ST_CLEAR) || (beat && ptr_ok);
   assign ram_waddr = (state_q == ST_CLEAR) ? clr_ptr_q : ptr_x[AW-1:0];
   assign ram_wdata = (state_q == ST_CLEAR) ? FILL_WORD : load_data;
   assign ram_re    = fetch_acc && !fetch_bad;

   imem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk_i   (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ram_re),
      .raddr_i (fetch_idx[AW-1:0]),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d     = state_q;
      clr_ptr_d   = clr_ptr_q;
      ptr_d       = ptr_q;
      rem_d       = rem_q;
      load_done_d = 1'b0;
      load_err_d  = load_err_q;
      case (state_q)
         ST_CLEAR: begin
            clr_ptr_d = clr_ptr_q + AW'(1);
            if (clr_ptr_q == AW'(DEPTH - 1)) begin
               state_d   = ST_IDLE;
               clr_ptr_d = '0;
            end
         end
         ST_IDLE: begin
            if (load_start) begin
               ptr_d      = load_base;
               rem_d      = load_len;
               load_err_d = 1'b0;
               if (load_len == '0) load_done_d = 1'b1;
               else                state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (beat) begin
               if (!ptr_ok) load_err_d = 1'b1;
               ptr_d = ptr_q + ADDR_W'(1);
               rem_d = rem_q - ADDR_W'(1);
               if (rem_q == ADDR_W'(1)) begin
                  state_d     = ST_IDLE;
                  load_done_d = 1'b1;
               end
            end
         end
         default: state_d = ST_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_CLEAR;
         clr_ptr_q   <= '0;
         ptr_q       <= '0;
         rem_q       <= '0;
         load_done_q <= 1'b0;
         load_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         ptr_q       <= ptr_d;
         rem_q       <= rem_d;
         load_done_q <= load_done_d;
         load_err_q  <= load_err_d;
      end
   end

   // Response register; use_fill_q selects FILL_WORD after reset and for faults.
   always_ff @(posedge clk) begin
      if (reset) begin
         iv_q       <= 1'b0;
         fault_q    <= 1'b0;
         use_fill_q <= 1'b1;
      end else if (fetch_acc) begin
         iv_q       <= 1'b1;
         fault_q    <= fetch_bad;
         use_fill_q <= fetch_bad;
      end else if (instr_ready) begin
         iv_q <= 1'b0;
      end
   end

   assign instr_valid = iv_q;
   assign instr_fault = fault_q;
   assign instruction = use_fill_q ? FILL_WORD : ram_rdata;
   assign load_done   = load_done_q;
   assign load_err    = load_err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Directed bench for instruction_memory_ctrl with default parameters (DEPTH=1024, byte addressing).
module tb_instruction_memory_ctrl;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] FILL  = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_valid;
   logic [31:0] fetch_addr;
   logic        fetch_ready;
   logic        instr_valid;
   logic [31:0] instruction;
   logic        instr_fault;
   logic        instr_ready;
   logic        load_start;
   logic [31:0] load_base;
   logic [31:0] load_len;
   logic        load_valid;
   logic [31:0] load_data;
   logic        load_ready;
   logic        load_done;
   logic        load_err;
   logic [1:0]  dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   logic [32:0] exp_q[$];
   logic [31:0] ld_q[$];

   always #5 clk = ~clk;

   instruction_memory_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_valid (fetch_valid),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .instr_valid (instr_valid),
      .instruction (instruction),
      .instr_fault (instr_fault),
      .instr_ready (instr_ready),
      .load_start  (load_start),
      .load_base   (load_base),
      .load_len    (load_len),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .load_err    (load_err),
      .dbg_state   (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_resp(input string tag);
      logic [32:0] e;
      check({tag, "_valid"}, instr_valid, 1);
      check({tag, "_sbq"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_data"}, instruction, e[31:0]);
         check({tag, "_fault"}, instr_fault, e[32]);
      end
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      fetch_valid = 1'b0;
      fetch_addr  = '0;
      instr_ready = 1'b1;
      load_start  = 1'b0;
      load_base   = '0;
      load_len    = '0;
      load_valid  = 1'b0;
      load_data   = '0;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic wait_clear(input string tag);
      logic bad;
      bad   = 1'b0;
      reset = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         #1;
         if (fetch_ready || load_ready || load_done) bad = 1'b1;
         @(negedge clk);
      end
      #1;
      check({tag, "_quiet"}, bad, 0);
      check({tag, "_ready_rise"}, fetch_ready, 1);
   endtask

   task automatic fetch_one(input string tag, input logic [31:0] addr,
                            input logic [31:0] word, input logic fault);
      fetch_valid = 1'b1;
      fetch_addr  = addr;
      instr_ready = 1'b1;
      #1;
      check({tag, "_ready"}, fetch_ready, 1);
      if (fetch_ready) exp_q.push_back({fault, word});
      @(negedge clk);
      fetch_valid = 1'b0;
      check_resp(tag);
      @(negedge clk);
   endtask

   task automatic fetch_seq(input logic [31:0] a [3], input logic [31:0] w [3]);
      for (int i = 0; i < 3; i++) begin
         fetch_valid = 1'b1;
         fetch_addr  = a[i];
         instr_ready = 1'b1;
         #1;
         check("b2b_ready", fetch_ready, 1);
         if (fetch_ready) exp_q.push_back({1'b0, w[i]});
         @(negedge clk);
         check_resp("b2b");
      end
      fetch_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic load_burst(input logic [31:0] base, input logic [31:0] len, input int abort_after);
      load_start  = 1'b1;
      load_base   = base;
      load_len    = len;
      fetch_valid = 1'b1;
      fetch_addr  = '0;
      #1;
      check("ld_start_blocks_fetch", fetch_ready, 0);
      @(negedge clk);
      load_start  = 1'b0;
      fetch_valid = 1'b0;
      if (len == 0) begin
         #1;
         check("ld_len0_done", load_done, 1);
         check("ld_len0_no_ready", load_ready, 0);
         @(negedge clk);
         check("ld_len0_done_once", load_done, 0);
         return;
      end
      for (int i = 0; i < int'(len); i++) begin
         if (i == abort_after) begin
            load_valid = 1'b0;
            return;
         end
         load_valid = 1'b1;
         load_data  = ld_q.pop_front();
         #1;
         check("ld_beat_ready", load_ready, 1);
         check("ld_no_fetch", fetch_ready, 0);
         check("ld_no_early_done", load_done, 0);
         @(negedge clk);
      end
      load_valid = 1'b0;
      #1;
      check("ld_done_pulse", load_done, 1);
      check("ld_ready_drop", load_ready, 0);
      @(negedge clk);
      check("ld_done_once", load_done, 0);
   endtask

   initial begin
      logic [31:0] fa [3];
      logic [31:0] fw [3];

      do_reset();
      check("rst_fetch_ready", fetch_ready, 0);
      check("rst_instr_valid", instr_valid, 0);
      check("rst_instruction", instruction, FILL);
      check("rst_instr_fault", instr_fault, 0);
      check("rst_load_ready", load_ready, 0);
      check("rst_load_done", load_done, 0);
      check("rst_load_err", load_err, 0);
      wait_clear("clear1");
      fetch_one("f_zero_fill", 32'h0, FILL, 1'b0);

      ld_q = '{32'h11, 32'h22, 32'h33};
      load_burst(32'd4, 32'd3, -1);
      check("ld1_err_clear", load_err, 0);
      fa = '{32'h10, 32'h14, 32'h18};
      fw = '{32'h11, 32'h22, 32'h33};
      fetch_seq(fa, fw);
      fetch_one("f_idx3_untouched", 32'hC, FILL, 1'b0);
      fetch_one("f_idx7_untouched", 32'h1C, FILL, 1'b0);

      fetch_one("f_misaligned", 32'h1002, FILL, 1'b1);
      fetch_one("f_out_of_range", 32'h1000, FILL, 1'b1);
      fetch_one("f_last_word", 32'hFFC, FILL, 1'b0);

      // Back-pressure: response at 0x14 held while a second fetch waits.
      fetch_valid = 1'b1;
      fetch_addr  = 32'h14;
      instr_ready = 1'b0;
      #1;
      check("bp_first_ready", fetch_ready, 1);
      if (fetch_ready) exp_q.push_back({1'b0, 32'h22});
      @(negedge clk);
      check_resp("bp_first");
      fetch_addr = 32'h18;
      #1;
      check("bp_stall_ready", fetch_ready, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         #1;
         check("bp_hold_data", instruction, 32'h22);
         check("bp_hold_valid", instr_valid, 1);
         check("bp_hold_ready", fetch_ready, 0);
      end
      instr_ready = 1'b1;
      #1;
      check("bp_release_ready", fetch_ready, 1);
      if (fetch_ready) exp_q.push_back({1'b0, 32'h33});
      @(negedge clk);
      check_resp("bp_second");
      fetch_valid = 1'b0;
      @(negedge clk);
      check("bp_valid_falls", instr_valid, 0);

      ld_q = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      load_burst(32'd1022, 32'd4, -1);
      check("ld_top_err", load_err, 1);
      fetch_one("f_1022", 32'hFF8, 32'hA0, 1'b0);
      fetch_one("f_1023", 32'hFFC, 32'hA1, 1'b0);
      fetch_one("f_nowrap0", 32'h0, FILL, 1'b0);
      fetch_one("f_nowrap1", 32'h4, FILL, 1'b0);
      check("ld_err_sticky", load_err, 1);

      load_burst(32'd0, 32'd0, -1);
      check("ld_len0_err_cleared", load_err, 0);

      ld_q = '{32'h55, 32'h66, 32'h77, 32'h88, 32'h99};
      load_burst(32'd0, 32'd5, 2);
      ld_q.delete();
      do_reset();
      check("rst2_load_done", load_done, 0);
      wait_clear("clear2");
      check("rst2_load_err", load_err, 0);
      fetch_one("f_rst_w0", 32'h0, FILL, 1'b0);
      fetch_one("f_rst_w1", 32'h4, FILL, 1'b0);
      fetch_one("f_rst_w4", 32'h10, FILL, 1'b0);
      fetch_one("f_rst_w1022", 32'hFF8, FILL, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
